// File: rtl/xreg_seq.sv
// rtl/xreg_seq.sv - X register write/read sequencer with bus-grant timeout
module xreg_seq #(
  parameter int TMO = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [3:0] cnt,
  input  logic       bus_gnt,
  output logic       xiz,
  output logic       xip,
  output logic       xis,
  output logic       xid,
  output logic       wrx,
  output logic       rdx,
  output logic       abus_req,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_REQ,
    S_READ,
    S_FIN
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_CLR = 3'b001;
  localparam logic [2:0] OP_LDP = 3'b010;
  localparam logic [2:0] OP_LDD = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b100;
  localparam logic [2:0] OP_RDA = 3'b101;

  // Last REQ cycle index (counter runs 0..TMO-1 while waiting for grant)
  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] tmo_q, tmo_d;

  logic xiz_q, xiz_d;
  logic xip_q, xip_d;
  logic xis_q, xis_d;
  logic xid_q, xid_d;
  logic wrx_q, wrx_d;
  logic rdx_q, rdx_d;
  logic abus_req_q, abus_req_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic wr_phase;

  // Next-state logic; outputs are decoded from the next state so every output is a flop
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = cnt;
          tmo_d = 4'd0;
          case (op)
            OP_CLR, OP_LDP, OP_LDD: state_d = S_SETUP;
            OP_SHF:                 state_d = (cnt != 4'd0) ? S_SETUP : S_FIN;
            OP_RDA:                 state_d = S_REQ;
            OP_NOP:                 state_d = S_FIN;
            default: begin
              state_d = S_FIN;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_HOLD;
      S_HOLD: begin
        if (op_q == OP_SHF && cnt_q > 4'd1) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_SETUP;
        end else begin
          // Saturate at zero; the count never wraps
          if (op_q == OP_SHF) cnt_d = 4'd0;
          state_d = S_FIN;
        end
      end
      S_REQ: begin
        if (bus_gnt) begin
          state_d = S_READ;
        end else if (tmo_q >= TMO_LAST) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_READ:  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_phase   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    xiz_d      = wr_phase && (op_d == OP_CLR);
    xip_d      = wr_phase && (op_d == OP_LDP);
    xid_d      = wr_phase && (op_d == OP_LDD);
    xis_d      = wr_phase && (op_d == OP_SHF);
    wrx_d      = (state_d == S_STROBE);
    rdx_d      = (state_d == S_READ);
    abus_req_d = (state_d == S_REQ) || (state_d == S_READ);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FIN);
  end

  // State, latched operands and registered outputs; async reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      cnt_q      <= 4'd0;
      tmo_q      <= 4'd0;
      xiz_q      <= 1'b0;
      xip_q      <= 1'b0;
      xis_q      <= 1'b0;
      xid_q      <= 1'b0;
      wrx_q      <= 1'b0;
      rdx_q      <= 1'b0;
      abus_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      xiz_q      <= xiz_d;
      xip_q      <= xip_d;
      xis_q      <= xis_d;
      xid_q      <= xid_d;
      wrx_q      <= wrx_d;
      rdx_q      <= rdx_d;
      abus_req_q <= abus_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign xiz      = xiz_q;
  assign xip      = xip_q;
  assign xis      = xis_q;
  assign xid      = xid_q;
  assign wrx      = wrx_q;
  assign rdx      = rdx_q;
  assign abus_req = abus_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
